// File: rtl/coin_animator.sv
// Coin sprite animator: sweeps a COIN_SIZE x COIN_SIZE sprite horizontally across
// the VGA frame, erasing/redrawing once per frame period, and reports completion.
module coin_animator #(
   parameter int         X_LEFT       = 20,
   parameter int         X_RIGHT      = 130,
   parameter int         Y_POS        = 60,
   parameter int         COIN_SIZE    = 4,
   parameter int         STEP         = 4,
   parameter int         FRAME_CYCLES = 833333,
   parameter logic [2:0] COIN_COLOUR  = 3'b110,
   parameter logic [2:0] BG_COLOUR    = 3'b000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_animation,
   input  logic       dir,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       done
);

   localparam int LOG = $clog2(COIN_SIZE);
   localparam int CW  = 2 * LOG;
   localparam int FW  = $clog2(FRAME_CYCLES + 1);

   localparam logic [CW-1:0] PIX_LAST   = '1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
   localparam logic [7:0]    XL         = 8'(X_LEFT);
   localparam logic [7:0]    XR         = 8'(X_RIGHT);
   localparam logic [8:0]    STEP9      = 9'(STEP);
   localparam logic [6:0]    Y0         = 7'(Y_POS);

   typedef enum logic [2:0] {IDLE, DRAW, WAIT, ERASE, MOVE, DONE} state_t;

   state_t          state;
   logic [7:0]      pos, target;
   logic            dir_r;
   logic [CW-1:0]   pix;
   logic [FW-1:0]   frame;
   logic [LOG-1:0]  col, row;
   logic [8:0]      pos_up;

   // COIN_SIZE is a power of two, so the pixel counter splits directly into row/col.
   assign col    = pix[LOG-1:0];
   assign row    = pix[CW-1:LOG];
   assign pos_up = {1'b0, pos} + STEP9;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         pos    <= '0;
         target <= '0;
         dir_r  <= 1'b0;
         pix    <= '0;
         frame  <= '0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         done   <= 1'b0;
      end else begin
         plot <= 1'b0;
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start_animation) begin
                  dir_r  <= dir;
                  pos    <= dir ? XR : XL;
                  target <= dir ? XL : XR;
                  pix    <= '0;
                  state  <= DRAW;
               end
            end
            DRAW, ERASE: begin
               x      <= pos + {{(8-LOG){1'b0}}, col};
               y      <= Y0 + {{(7-LOG){1'b0}}, row};
               colour <= (state == DRAW) ? COIN_COLOUR : BG_COLOUR;
               plot   <= 1'b1;
               // Counter wraps to zero on the last pixel, ready for the next sweep.
               pix    <= pix + 1'b1;
               if (pix == PIX_LAST)
                  state <= (state == DRAW) ? WAIT : MOVE;
            end
            WAIT: begin
               if (frame == FRAME_LAST) begin
                  frame <= '0;
                  if (pos == target) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ERASE;
                  end
               end else begin
                  frame <= frame + 1'b1;
               end
            end
            MOVE: begin
               // Clamp in 9 bits so the final partial step lands exactly on target.
               if (!dir_r)
                  pos <= (pos_up >= {1'b0, target}) ? target : pos_up[7:0];
               else
                  pos <= ({1'b0, pos} <= {1'b0, target} + STEP9) ? target : pos - STEP9[7:0];
               state <= DRAW;
            end
            DONE: begin
               if (!start_animation) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coin_animator.sv
// Self-checking bench for coin_animator: captures every plotted pixel and compares
// the write stream, its timing and the final frame against a sprite-motion model.
module tb_coin_animator;

   localparam int F  = 4;
   localparam int S  = 2;
   localparam int N  = S * S;
   localparam int XL = 20;
   localparam int XR = 30;
   localparam int YP = 60;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            dir   = 1'b0;
   logic [1:0]      start = '0;
   logic [1:0][7:0] xv;
   logic [1:0][6:0] yv;
   logic [1:0][2:0] cv;
   logic [1:0]      plotv, donev;

   coin_animator #(.X_LEFT(XL), .X_RIGHT(XR), .Y_POS(YP), .COIN_SIZE(S), .STEP(4),
                   .FRAME_CYCLES(F), .COIN_COLOUR(3'b110), .BG_COLOUR(3'b000)) dut (
      .clock(clock), .reset(reset), .start_animation(start[0]), .dir(dir),
      .x(xv[0]), .y(yv[0]), .colour(cv[0]), .plot(plotv[0]), .done(donev[0]));

   // Single-move instance: STEP spans the whole track.
   coin_animator #(.X_LEFT(XL), .X_RIGHT(XR), .Y_POS(YP), .COIN_SIZE(S), .STEP(XR-XL),
                   .FRAME_CYCLES(F), .COIN_COLOUR(3'b110), .BG_COLOUR(3'b000)) dut1 (
      .clock(clock), .reset(reset), .start_animation(start[1]), .dir(dir),
      .x(xv[1]), .y(yv[1]), .colour(cv[1]), .plot(plotv[1]), .done(donev[1]));

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Each write packed as {cycle, x, y, colour}.
   logic [55:0] cap0[$], cap1[$], gotq[$], expq[$];
   always @(negedge clock) begin
      if (plotv[0]) cap0.push_back({32'(cyc), xv[0], 1'b0, yv[0], 5'b0, cv[0]});
      if (plotv[1]) cap1.push_back({32'(cyc), xv[1], 1'b0, yv[1], 5'b0, cv[1]});
   end

   int total = 0, bad = 0;
   int done_rel, exp_done, draws_e, erases_e;
   logic [2:0] fb [0:159][0:119];

   // Expected writes: sprite draws at successive positions, erased between frames.
   function automatic void model(input int step, input bit d);
      int p, tgt, t;
      expq.delete();
      p = d ? XR : XL;  tgt = d ? XL : XR;  t = 0;  draws_e = 0;  erases_e = 0;
      for (int g = 0; g < 200; g++) begin
         for (int k = 0; k < N; k++) expq.push_back({32'(t+k), 8'(p+k%S), 8'(YP+k/S), 8'd6});
         draws_e++;
         if (p == tgt) begin
            exp_done = t + N - 1 + F;
            break;
         end
         t += N + F;
         for (int k = 0; k < N; k++) expq.push_back({32'(t+k), 8'(p+k%S), 8'(YP+k/S), 8'd0});
         erases_e++;
         t += N + 1;
         p = d ? ((p - step < tgt) ? tgt : p - step) : ((p + step > tgt) ? tgt : p + step);
      end
   endfunction

   task automatic run_anim(input int sel, input bit d, input bit hold, input bit toggle);
      int base;
      repeat ($urandom_range(0, 5)) @(negedge clock);
      cap0.delete();  cap1.delete();
      dir = d;  start[sel] = 1'b1;  base = cyc + 2;  done_rel = -1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clock);
         if (!hold) start[sel] = 1'b0;
         if (toggle) dir = 1'($urandom_range(0, 1));
         if (donev[sel]) begin
            done_rel = cyc - base;
            break;
         end
      end
      dir = 1'b0;
      total++;
      if (done_rel < 0) begin
         bad++;
         $display("FAIL done_timeout dut%0d: done never rose within 3000 cycles", sel);
      end
      repeat (3) @(negedge clock);
      gotq.delete();
      if (sel == 0) foreach (cap0[i]) gotq.push_back({cap0[i][55:24] - 32'(base), cap0[i][23:0]});
      else          foreach (cap1[i]) gotq.push_back({cap1[i][55:24] - 32'(base), cap1[i][23:0]});
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      for (int s = 0; s < 2; s++) begin
         total++;
         if ({xv[s], yv[s], cv[s], plotv[s], donev[s]} !== 20'd0) begin
            bad++;
            $display("FAIL reset_outputs dut%0d: got x=%0d y=%0d c=%0d plot=%b done=%b want all 0",
                     s, xv[s], yv[s], cv[s], plotv[s], donev[s]);
         end
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_directions();
      int nd, ne, nz, tgt;
      for (int d = 0; d < 2; d++) begin
         run_anim(0, 1'(d), 1'b0, 1'b0);
         model(4, 1'(d));
         total++;
         if (gotq.size() != expq.size()) begin
            bad++;
            $display("FAIL dir%0d_write_count: got %0d want %0d", d, gotq.size(), expq.size());
         end
         foreach (expq[i]) if (i < gotq.size()) begin
            total++;
            if (gotq[i] !== expq[i]) begin
               bad++;
               $display("FAIL dir%0d_write[%0d]: got %h want %h", d, i, gotq[i], expq[i]);
            end
         end
         total++;
         if (done_rel !== exp_done) begin
            bad++;
            $display("FAIL dir%0d_done_time: got %0d want %0d", d, done_rel, exp_done);
         end
         nd = 0;  ne = 0;
         foreach (gotq[i]) if (gotq[i][2:0] == 3'b110) nd++; else ne++;
         total++;
         if (nd != 4 * N || ne != 3 * N) begin
            bad++;
            $display("FAIL dir%0d_frames: got draws=%0d erases=%0d want 4 and 3", d, nd / N, ne / N);
         end
         for (int i = 0; i < 160; i++) for (int j = 0; j < 120; j++) fb[i][j] = 3'd0;
         foreach (gotq[i]) fb[int'(gotq[i][23:16])][int'(gotq[i][14:8])] = gotq[i][2:0];
         tgt = d ? XL : XR;  nz = 0;
         for (int i = 0; i < 160; i++) for (int j = 0; j < 120; j++) if (fb[i][j] != 3'd0) nz++;
         for (int k = 0; k < N; k++) begin
            total++;
            if (fb[tgt + k % S][YP + k / S] !== 3'b110) begin
               bad++;
               $display("FAIL dir%0d_final_pixel (%0d,%0d): got %b want 110", d,
                        tgt + k % S, YP + k / S, fb[tgt + k % S][YP + k / S]);
            end
         end
         total++;
         if (nz != N) begin
            bad++;
            $display("FAIL dir%0d_leftover_pixels: got %0d lit want %0d", d, nz, N);
         end
      end
   endtask

   task automatic test_hold_retrigger();
      run_anim(0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         total++;
         if (donev[0] !== 1'b1 || plotv[0] !== 1'b0) begin
            bad++;
            $display("FAIL hold_done: got done=%b plot=%b want done=1 plot=0", donev[0], plotv[0]);
         end
      end
      start[0] = 1'b0;
      @(negedge clock);
      total++;
      if (donev[0] !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: got done=%b want 0", donev[0]);
      end
      run_anim(0, 1'b0, 1'b0, 1'b0);
      model(4, 1'b0);
      total++;
      if (gotq.size() != expq.size()) begin
         bad++;
         $display("FAIL retrigger_write_count: got %0d want %0d", gotq.size(), expq.size());
      end
      foreach (expq[i]) if (i < gotq.size()) begin
         total++;
         if (gotq[i] !== expq[i]) begin
            bad++;
            $display("FAIL retrigger_write[%0d]: got %h want %h", i, gotq[i], expq[i]);
         end
      end
   endtask

   task automatic test_reset_mid_erase();
      bit seen = 0;
      dir = 1'b0;  start[0] = 1'b1;
      @(negedge clock);
      start[0] = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clock);
         if (plotv[0] && cv[0] == 3'b000) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL erase_timeout: no erase write within 200 cycles");
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({xv[0], yv[0], cv[0], plotv[0], donev[0]} !== 20'd0) begin
         bad++;
         $display("FAIL async_reset: got x=%0d y=%0d c=%0d plot=%b done=%b want all 0",
                  xv[0], yv[0], cv[0], plotv[0], donev[0]);
      end
      @(negedge clock);
      reset = 1'b0;
      cap0.delete();
      repeat (20) @(negedge clock);
      total++;
      if (cap0.size() != 0 || donev[0] !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: got writes=%0d done=%b want 0 and 0", cap0.size(), donev[0]);
      end
   endtask

   task automatic test_dir_toggle();
      run_anim(0, 1'b0, 1'b0, 1'b1);
      model(4, 1'b0);
      total++;
      if (gotq.size() != expq.size()) begin
         bad++;
         $display("FAIL toggle_write_count: got %0d want %0d", gotq.size(), expq.size());
      end
      foreach (expq[i]) if (i < gotq.size()) begin
         total++;
         if (gotq[i] !== expq[i]) begin
            bad++;
            $display("FAIL toggle_write[%0d]: got %h want %h", i, gotq[i], expq[i]);
         end
      end
   endtask

   task automatic test_single_move();
      bit d = 1'($urandom_range(0, 1));
      int nd = 0, ne = 0;
      run_anim(1, d, 1'b0, 1'b0);
      model(XR - XL, d);
      foreach (gotq[i]) if (gotq[i][2:0] == 3'b110) nd++; else ne++;
      total++;
      if (nd != 2 * N || ne != N) begin
         bad++;
         $display("FAIL single_frames: got draws=%0d erases=%0d want 2 and 1", nd / N, ne / N);
      end
      foreach (expq[i]) if (i < gotq.size()) begin
         total++;
         if (gotq[i] !== expq[i]) begin
            bad++;
            $display("FAIL single_write[%0d]: got %h want %h", i, gotq[i], expq[i]);
         end
      end
      total++;
      if (done_rel !== exp_done || gotq.size() != expq.size()) begin
         bad++;
         $display("FAIL single_done: got t=%0d n=%0d want t=%0d n=%0d",
                  done_rel, gotq.size(), exp_done, expq.size());
      end
   endtask

   task automatic test_random();
      int sel;
      bit d, hold;
      for (int r = 0; r < 6; r++) begin
         sel  = $urandom_range(0, 1);
         d    = 1'($urandom_range(0, 1));
         hold = 1'($urandom_range(0, 1));
         run_anim(sel, d, hold, 1'b0);
         start[sel] = 1'b0;
         @(negedge clock);
         model(sel ? XR - XL : 4, d);
         total++;
         if (gotq.size() != expq.size() || done_rel !== exp_done) begin
            bad++;
            $display("FAIL rand%0d_shape: got n=%0d t=%0d want n=%0d t=%0d",
                     r, gotq.size(), done_rel, expq.size(), exp_done);
         end
         foreach (expq[i]) if (i < gotq.size()) begin
            total++;
            if (gotq[i] !== expq[i]) begin
               bad++;
               $display("FAIL rand%0d_write[%0d]: got %h want %h", r, i, gotq[i], expq[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directions();
      test_hold_retrigger();
      test_reset_mid_erase();
      test_dir_toggle();
      test_single_move();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
